// File: rtl/mor1kx_wb_stage_cappuccino_pkg.sv
// Shared definitions for the cappuccino write-back stage: LSU length codes
// and write-back FSM state encoding.
package mor1kx_wb_stage_cappuccino_pkg;

   localparam int LOAD_WORD_WIDTH = 32;

   localparam logic [1:0] LSU_LENGTH_BYTE = 2'b00;
   localparam logic [1:0] LSU_LENGTH_HALF = 2'b01;
   localparam logic [1:0] LSU_LENGTH_WORD = 2'b10;

   typedef enum logic {
      WB_IDLE   = 1'b0,
      WB_RETIRE = 1'b1
   } wb_state_t;

endpackage

// File: rtl/mor1kx_wb_stage_cappuccino_if.sv
// Signal bundle between ctrl/LSU/SPR/multiplier sources and the write-back
// stage, plus the register-file facing outputs of the stage.
interface mor1kx_wb_stage_cappuccino_if #(
   parameter int OPTION_OPERAND_WIDTH = 32,
   parameter int OPTION_RF_ADDR_WIDTH = 5
);
   logic                            padv_wb_i;
   logic                            pipeline_flush_i;
   logic                            ctrl_valid_i;
   logic                            ctrl_rf_wb_i;
   logic [OPTION_RF_ADDR_WIDTH-1:0] ctrl_rfd_adr_i;
   logic                            ctrl_op_lsu_load_i;
   logic [1:0]                      ctrl_lsu_length_i;
   logic                            ctrl_lsu_zext_i;
   logic [1:0]                      ctrl_lsu_adr_i;
   logic                            ctrl_op_mfspr_i;
   logic                            ctrl_op_mul_i;
   logic [OPTION_OPERAND_WIDTH-1:0] ctrl_alu_result_i;
   logic [OPTION_OPERAND_WIDTH-1:0] lsu_dat_i;
   logic [OPTION_OPERAND_WIDTH-1:0] spr_dat_i;
   logic [OPTION_OPERAND_WIDTH-1:0] mul_result_i;
   logic                            wb_rf_wb_o;
   logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o;
   logic [OPTION_OPERAND_WIDTH-1:0] result_o;
   logic                            wb_valid_o;

   modport master (
      output padv_wb_i, pipeline_flush_i, ctrl_valid_i, ctrl_rf_wb_i,
             ctrl_rfd_adr_i, ctrl_op_lsu_load_i, ctrl_lsu_length_i,
             ctrl_lsu_zext_i, ctrl_lsu_adr_i, ctrl_op_mfspr_i, ctrl_op_mul_i,
             ctrl_alu_result_i, lsu_dat_i, spr_dat_i, mul_result_i,
      input  wb_rf_wb_o, wb_rfd_adr_o, result_o, wb_valid_o
   );

   modport slave (
      input  padv_wb_i, pipeline_flush_i, ctrl_valid_i, ctrl_rf_wb_i,
             ctrl_rfd_adr_i, ctrl_op_lsu_load_i, ctrl_lsu_length_i,
             ctrl_lsu_zext_i, ctrl_lsu_adr_i, ctrl_op_mfspr_i, ctrl_op_mul_i,
             ctrl_alu_result_i, lsu_dat_i, spr_dat_i, mul_result_i,
      output wb_rf_wb_o, wb_rfd_adr_o, result_o, wb_valid_o
   );
endinterface

// File: rtl/mor1kx_wb_stage_cappuccino_lsu_load_align.sv
// Big-endian load alignment and zero/sign extension of a 32-bit bus word.
// Purely combinational so the LSU can share it.
module mor1kx_lsu_load_align
   import mor1kx_wb_stage_cappuccino_pkg::*;
(
   input  logic [LOAD_WORD_WIDTH-1:0] i_dat,
   input  logic [1:0]                 i_length,
   input  logic                       i_zext,
   input  logic [1:0]                 i_adr,
   output logic [LOAD_WORD_WIDTH-1:0] o_dat
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first,
      // otherwise an incomplete case infers a latch.
      w_byte = i_dat[7:0];
      case (i_adr)
         2'd0:    w_byte = i_dat[31:24];
         2'd1:    w_byte = i_dat[23:16];
         2'd2:    w_byte = i_dat[15:8];
         default: w_byte = i_dat[7:0];
      endcase
   end

   assign w_half = i_adr[1] ? i_dat[15:0] : i_dat[31:16];

   always_comb begin
      o_dat = i_dat;
      case (i_length)
         LSU_LENGTH_BYTE: o_dat = {{24{w_byte[7] & ~i_zext}}, w_byte};
         LSU_LENGTH_HALF: o_dat = {{16{w_half[15] & ~i_zext}}, w_half};
         default:         o_dat = i_dat;  // word, and the unused code 11
      endcase
   end

endmodule

// File: rtl/mor1kx_wb_stage_cappuccino.sv
// Cappuccino write-back stage: selects the retiring result, aligns load data,
// and registers the RF write strobe, address and data.
module mor1kx_wb_stage_cappuccino
   import mor1kx_wb_stage_cappuccino_pkg::*;
#(
   parameter int OPTION_OPERAND_WIDTH = 32,
   parameter int OPTION_RF_ADDR_WIDTH = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   mor1kx_wb_stage_cappuccino_if.slave  bus
);

   wb_state_t                       r_state;
   logic                            r_rf_wb;
   logic [OPTION_RF_ADDR_WIDTH-1:0] r_rfd_adr;
   logic [OPTION_OPERAND_WIDTH-1:0] r_result;

   logic [OPTION_OPERAND_WIDTH-1:0] w_load_dat;
   logic [OPTION_OPERAND_WIDTH-1:0] w_result;
   logic                            w_retire;

   mor1kx_lsu_load_align u_load_align (
      .i_dat    (bus.lsu_dat_i),
      .i_length (bus.ctrl_lsu_length_i),
      .i_zext   (bus.ctrl_lsu_zext_i),
      .i_adr    (bus.ctrl_lsu_adr_i),
      .o_dat    (w_load_dat)
   );

   always_comb begin
      w_result = bus.ctrl_alu_result_i;
      if (bus.ctrl_op_lsu_load_i)
         w_result = w_load_dat;
      else if (bus.ctrl_op_mfspr_i)
         w_result = bus.spr_dat_i;
      else if (bus.ctrl_op_mul_i)
         w_result = bus.mul_result_i;
   end

   // A flushed or invalid slot still advances (data captured) but never retires.
   assign w_retire = bus.padv_wb_i & bus.ctrl_valid_i & ~bus.pipeline_flush_i;

   // The strobe is decided at the advance edge so it leaves the stage as a
   // plain register; r0 writes are dropped here rather than in the RF.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         r_state   <= WB_IDLE;
         r_rf_wb   <= 1'b0;
         r_rfd_adr <= '0;
         r_result  <= '0;
      end else begin
         r_state <= w_retire ? WB_RETIRE : WB_IDLE;
         r_rf_wb <= w_retire & bus.ctrl_rf_wb_i & (bus.ctrl_rfd_adr_i != '0);
         if (bus.padv_wb_i) begin
            r_rfd_adr <= bus.ctrl_rfd_adr_i;
            r_result  <= w_result;
         end
      end
   end

   assign bus.wb_rf_wb_o   = r_rf_wb;
   assign bus.wb_rfd_adr_o = r_rfd_adr;
   assign bus.result_o     = r_result;
   assign bus.wb_valid_o   = (r_state == WB_RETIRE);

endmodule

// File: tb/tb_mor1kx_wb_stage_cappuccino.sv
// Self-checking bench for the write-back stage: directed cases followed by
// random traffic compared against a behavioural model of the retire rules.
module tb_mor1kx_wb_stage_cappuccino;

   logic clk;
   logic rst;

   mor1kx_wb_stage_cappuccino_if bus ();

   mor1kx_wb_stage_cappuccino dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic        exp_rf_wb;
   logic        exp_valid;
   logic [4:0]  exp_adr;
   logic [31:0] exp_result;

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
   endtask

   // Load data computed arithmetically from byte lanes (big-endian).
   function automatic logic [31:0] model_load(input logic [31:0] dat,
      input logic [1:0] len, input logic zext, input logic [1:0] adr);
      int unsigned v;
      if (len == 2'b00) begin
         v = (dat >> ((3 - int'(adr)) * 8)) & 32'hFF;
         if (!zext && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (len == 2'b01) begin
         v = (dat >> (adr[1] ? 0 : 16)) & 32'hFFFF;
         if (!zext && v >= 32768) v = v + 32'hFFFF_0000;
      end else begin
         v = dat;
      end
      return v;
   endfunction

   function automatic logic [31:0] model_result();
      if (bus.ctrl_op_lsu_load_i)
         return model_load(bus.lsu_dat_i, bus.ctrl_lsu_length_i,
                           bus.ctrl_lsu_zext_i, bus.ctrl_lsu_adr_i);
      if (bus.ctrl_op_mfspr_i) return bus.spr_dat_i;
      if (bus.ctrl_op_mul_i)   return bus.mul_result_i;
      return bus.ctrl_alu_result_i;
   endfunction

   // Predict the post-edge outputs from the current inputs, clock once, compare.
   task automatic step(input string tag);
      logic retire;
      if (rst) begin
         exp_rf_wb = 0; exp_valid = 0; exp_adr = 0; exp_result = 0;
      end else begin
         retire    = bus.padv_wb_i && bus.ctrl_valid_i && !bus.pipeline_flush_i;
         exp_valid = retire;
         exp_rf_wb = retire && bus.ctrl_rf_wb_i && (bus.ctrl_rfd_adr_i != 0);
         if (bus.padv_wb_i) begin
            exp_adr    = bus.ctrl_rfd_adr_i;
            exp_result = model_result();
         end
      end
      @(posedge clk);
      #1;
      check({tag, ".rf_wb"},  32'(bus.wb_rf_wb_o),   32'(exp_rf_wb));
      check({tag, ".valid"},  32'(bus.wb_valid_o),   32'(exp_valid));
      check({tag, ".adr"},    32'(bus.wb_rfd_adr_o), 32'(exp_adr));
      check({tag, ".result"}, bus.result_o,          exp_result);
   endtask

   task automatic idle_inputs();
      bus.padv_wb_i = 0; bus.pipeline_flush_i = 0; bus.ctrl_valid_i = 0;
      bus.ctrl_rf_wb_i = 0; bus.ctrl_rfd_adr_i = 0; bus.ctrl_op_lsu_load_i = 0;
      bus.ctrl_lsu_length_i = 0; bus.ctrl_lsu_zext_i = 0; bus.ctrl_lsu_adr_i = 0;
      bus.ctrl_op_mfspr_i = 0; bus.ctrl_op_mul_i = 0; bus.ctrl_alu_result_i = 0;
      bus.lsu_dat_i = 0; bus.spr_dat_i = 0; bus.mul_result_i = 0;
   endtask

   task automatic alu_write(input logic [4:0] adr, input logic [31:0] val);
      bus.padv_wb_i = 1; bus.ctrl_valid_i = 1; bus.ctrl_rf_wb_i = 1;
      bus.ctrl_op_lsu_load_i = 0; bus.ctrl_op_mfspr_i = 0; bus.ctrl_op_mul_i = 0;
      bus.ctrl_rfd_adr_i = adr; bus.ctrl_alu_result_i = val;
   endtask

   task automatic load(input logic [4:0] adr, input logic [31:0] dat,
                       input logic [1:0] len, input logic zext,
                       input logic [1:0] ladr);
      alu_write(adr, 32'hCAFE_0000);
      bus.ctrl_op_lsu_load_i = 1; bus.lsu_dat_i = dat;
      bus.ctrl_lsu_length_i = len; bus.ctrl_lsu_zext_i = zext;
      bus.ctrl_lsu_adr_i = ladr;
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      #1;
      step("reset");
      step("reset2");
      rst = 0;
      step("idle");

      // Byte load, sign-extended
      load(5'd1, 32'h1285_3456, 2'b00, 1'b0, 2'd1);
      step("byte_sext");
      check("byte_sext.value", bus.result_o, 32'hFFFF_FF85);
      idle_inputs();
      step("byte_after");

      // Half load, both extensions
      load(5'd2, 32'h1234_8001, 2'b01, 1'b1, 2'd2);
      step("half_zext");
      check("half_zext.value", bus.result_o, 32'h0000_8001);
      load(5'd2, 32'h1234_8001, 2'b01, 1'b0, 2'd2);
      step("half_sext");
      check("half_sext.value", bus.result_o, 32'hFFFF_8001);
      load(5'd2, 32'h8123_4567, 2'b11, 1'b0, 2'd3);
      step("len11_word");

      // Write to r0 retires but never strobes
      alu_write(5'd0, 32'hDEAD_BEEF);
      step("r0_write");
      check("r0_write.value", bus.result_o, 32'hDEAD_BEEF);

      // Back-to-back retires then a stall
      alu_write(5'd3, 32'd1); step("b2b_r3");
      alu_write(5'd4, 32'd2); step("b2b_r4");
      alu_write(5'd5, 32'd3); step("b2b_r5");
      idle_inputs();
      step("stall");
      check("stall.held", bus.result_o, 32'd3);

      // Source priority
      alu_write(5'd6, 32'h1111_1111);
      bus.ctrl_op_mfspr_i = 1; bus.spr_dat_i = 32'h2222_2222;
      bus.ctrl_op_mul_i = 1; bus.mul_result_i = 32'h3333_3333;
      step("mfspr_prio");
      bus.ctrl_op_mfspr_i = 0;
      step("mul_prio");

      // Flush coincident with advance
      alu_write(5'd7, 32'h7777_7777);
      bus.pipeline_flush_i = 1;
      step("flush");
      check("flush.adr_captured", 32'(bus.wb_rfd_adr_o), 32'd7);
      idle_inputs();

      // Advance of an invalid slot
      alu_write(5'd8, 32'h8888_8888);
      bus.ctrl_valid_i = 0;
      step("invalid");

      // Reset in the middle of a retire burst
      alu_write(5'd9, 32'h9999_9999); step("pre_reset");
      alu_write(5'd10, 32'hAAAA_AAAA);
      rst = 1;
      step("mid_reset");
      rst = 0;
      idle_inputs();
      step("post_reset");

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         bus.padv_wb_i          = ($urandom_range(0, 3) != 0);
         bus.pipeline_flush_i   = ($urandom_range(0, 7) == 0);
         bus.ctrl_valid_i       = ($urandom_range(0, 5) != 0);
         bus.ctrl_rf_wb_i       = ($urandom_range(0, 4) != 0);
         bus.ctrl_rfd_adr_i     = 5'($urandom_range(0, 31));
         bus.ctrl_op_lsu_load_i = ($urandom_range(0, 2) == 0);
         bus.ctrl_lsu_length_i  = 2'($urandom_range(0, 3));
         bus.ctrl_lsu_zext_i    = 1'($urandom_range(0, 1));
         bus.ctrl_lsu_adr_i     = 2'($urandom_range(0, 3));
         bus.ctrl_op_mfspr_i    = ($urandom_range(0, 3) == 0);
         bus.ctrl_op_mul_i      = ($urandom_range(0, 3) == 0);
         bus.ctrl_alu_result_i  = $urandom;
         bus.lsu_dat_i          = $urandom;
         bus.spr_dat_i          = $urandom;
         bus.mul_result_i       = $urandom;
         rst                    = ($urandom_range(0, 63) == 0);
         step("random");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
